uart_rx_ascii: RTL
==================

Name: uart_rx_ascii

Overview:
- Serial UART receiver that sits directly upstream of the ASCII-to-seven-segment decoder.
- Oversamples the asynchronous rx pin, frames 8N1 characters, and presents the last good byte on a held 8-bit bus that drives the decoder input.
- Gives a one-cycle strobe per received character, plus a framing-error strobe.
- The held byte resets to ASCII space (0x20), so the display is blank after reset.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s.
- Derived (localparam, not overridable): CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide), HALF_BIT = CLKS_PER_BIT/2.
- Elaboration must fail if CLKS_PER_BIT < 4.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  asynchronous serial line; idles high.
- rx_data  output  8  last correctly framed byte, held until the next good byte.
- rx_valid  output  1  one-cycle strobe: rx_data updated this cycle.
- frame_err  output  1  one-cycle strobe: stop bit sampled low.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0:
  - sync FFs = 1, state = IDLE, counters = 0;
  - rx_data = 8'h20, rx_valid = 0, frame_err = 0, busy = 0.
  - Reset mid-frame abandons the frame; the partial byte is discarded.
- Input sync: rx passes through a 2-FF synchronizer to give rx_s. All decisions use rx_s only.
- Counters:
  - bit-timer counts 0..CLKS_PER_BIT-1 and is cleared on every state entry.
  - bit index is 3 bits, 0..7.
- FSM (registered outputs):
  - IDLE: rx_s=0 -> START, timer cleared.
  - START: on timer=HALF_BIT-1, if rx_s=0 -> DATA (timer and index cleared); if rx_s=1, treat as a glitch -> IDLE with no strobe.
  - DATA: on timer=CLKS_PER_BIT-1, sample rx_s into the shift register LSB-first (shift right, new bit enters bit 7), then increment index. After the sample at index 7 -> STOP.
  - STOP: on timer=CLKS_PER_BIT-1, sample rx_s.
    - If 1: rx_data <= shift register and rx_valid=1 in the same cycle -> IDLE.
    - If 0: frame_err=1, rx_data unchanged -> WAIT_HIGH.
  - WAIT_HIGH: stays until rx_s=1 -> IDLE. This prevents a break condition from being decoded as a stream of 0x00.
- Sampling points: the start bit is checked at mid-bit; every data and stop sample is then one full bit period later, so all samples are mid-bit.
- Latency: rx_valid rises 2 + HALF_BIT + 9*CLKS_PER_BIT clocks (+/-1) after the rx falling edge of the start bit.
- Strobes: rx_valid and frame_err are never high in the same cycle, and each is exactly one cycle wide.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start edge arriving exactly one bit time after the stop-bit start is caught. No gap is required.
- rx_data is stable between rx_valid strobes. The downstream decoder may sample it combinationally at any time.
- busy = (state != IDLE), registered together with the state.

Test Plan (CLK_FREQ=160, BAUD=10 -> CLKS_PER_BIT=16, HALF_BIT=8):
- Reset with rx=1 -> rx_data=0x20, rx_valid=0, frame_err=0, busy=0. After rst_n release, 100 idle clocks -> no change.
- Send 0x41 ('A'), 8N1 -> exactly one rx_valid pulse; rx_data=0x41 from that cycle on and held; frame_err never asserts; busy returns to 0.
- rx low for 4 clocks, then high (glitch < HALF_BIT) -> busy pulses briefly, no rx_valid, no frame_err, rx_data unchanged.
- Send 0x55 with stop bit forced 0 and rx held low 50 more clocks -> one frame_err pulse; rx_data still 0x41; busy stays 1 until rx returns high. Then send 0x7A -> rx_data=0x7A with one rx_valid.
- Send 0x30 then 0x39 back-to-back with no idle gap -> two rx_valid pulses 160 clocks apart, values 0x30 then 0x39, no frame_err.
- Assert rst_n=0 during data bit 3 of 0x4E -> outputs reset immediately (rx_data=0x20, busy=0). Release reset, send 0x21 -> rx_data=0x21 with one rx_valid.

Source files
------------

// File: rtl/uart_rx_ascii.sv
// 8N1 UART receiver feeding the ASCII seven-segment decoder.
// Holds the last good byte (space after reset) and strobes valid / framing error.
module uart_rx_ascii #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TW           = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(HALF_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_rx_ascii: CLKS_PER_BIT must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            busy_q, busy_d;
  logic            meta_q, rx_s_q;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      meta_q <= rx;
      rx_s_q <= meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (timer_q == HALF_M1) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      // A held-low line (break) must not decode as repeated 0x00.
      S_WAIT: begin
        timer_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= 8'h20;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule
